icache_fill_ctrl: RTL and testbench
===================================

Name: icache_fill_ctrl

Overview:
Miss-handling controller for the instruction cache: the memory-facing end of the cache fill interface. It accepts a miss indication and address, then issues eight sequential 16-bit word reads to the pipelined instruction memory. Each returned word is streamed into the cache data array with a per-word write strobe. After the last word it writes the 6-bit tag into the metadata array, and it holds the pipeline stall the whole time.

Parameters:
WORDS_PER_BLOCK, 8, words per cache block; the counter width is log2 of this value (3 bits).
TAG_W, 6, tag width; the tag is addr[15:10].

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
miss_detected  input  1  cache miss indication, sampled only in IDLE
miss_address  input  16  faulting fetch address
memory_data_valid  input  1  instruction memory read data valid
memory_data  input  16  instruction memory read data
fsm_busy  output  1  stall request to the fetch stage
memory_enable  output  1  memory read request
memory_address  output  16  memory read address
write_data_array  output  1  data array write enable (one word)
fill_address  output  16  address that selects the data array block/word being written
fill_data  output  16  word written to the data array
write_tag_array  output  1  metadata (tag/valid/LRU) write enable
tag_out  output  6  tag written to the metadata array

Behaviour:
- States: IDLE, FILL, TAG. State register and counters are async-cleared when rst=0.
- Reset values: state=IDLE, base=0, tag=0, issue_cnt=0, recv_cnt=0. All outputs are 0.
- IDLE:
  - fsm_busy=0, all strobes 0.
  - On a clk edge with miss_detected=1: latch base={miss_address[15:4],4'h0} and tag=miss_address[15:10], clear both counters, move to FILL.
- FILL:
  - fsm_busy=1.
  - Issue side:
    - memory_enable=1 while issue_done=0; memory_address=base+{issue_cnt,1'b0}.
    - issue_cnt increments every cycle memory_enable=1. When it wraps 7->0, issue_done is set.
    - There is no backpressure, so issue occupies exactly 8 consecutive cycles.
  - Receive side:
    - When memory_data_valid=1: write_data_array=1, fill_data=memory_data, fill_address=base+{recv_cnt,1'b0}, recv_cnt increments.
  - The last valid word (recv_cnt==7 and valid) moves the state to TAG.
- TAG:
  - Exactly one cycle: write_tag_array=1, tag_out=latched tag, fsm_busy=1. Then return to IDLE.
- Output timing:
  - memory_enable, memory_address, write_data_array, fill_address, fill_data, write_tag_array are combinational from state, counters and memory_data_valid. There is no added latency from valid to write.
  - tag_out shows the latched tag in every state; it is meaningful only while write_tag_array=1.
- Issue/receive overlap:
  - Data returning while issue is still in progress is accepted in the same cycle.
  - Receive order equals issue order; memory is in-order.
- Ignored inputs:
  - miss_detected is ignored outside IDLE.
  - memory_data_valid is ignored in IDLE and TAG. Words beyond the 8th are never written.
- Address arithmetic:
  - 16-bit, with no carry out of the block. Offsets stay within base..base+0xE; e.g. base 0xFFF0 ends at 0xFFFE.
- Reset mid-fill:
  - Immediate return to IDLE and all strobes drop asynchronously.
  - The tag has not been written, so partially written words are never hit.
- Miss latency: the miss edge is at cycle 0.
  - FILL runs cycles 1..8 for issue.
  - With 4-cycle memory, data is valid in cycles 5..12; TAG is cycle 13; IDLE from cycle 14.
  - fsm_busy is high cycles 1..13.

Test Plan:
- Reset: rst=0 with random inputs -> every output 0, state IDLE. Release rst; no miss -> fsm_busy stays 0 for 20 cycles.
- Basic fill: miss_address=0x1236, 4-cycle memory returning 0xA000+i.
  - memory_address 0x1230,0x1232,...,0x123E in cycles 1..8.
  - write_data_array in cycles 5..12 with fill_address 0x1230.. and fill_data 0xA000..0xA007.
  - write_tag_array=1 with tag_out=0x04 in cycle 13 only; fsm_busy high cycles 1..13.
- Top-of-memory wrap: miss_address=0xFFFA -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000; tag_out=0x3F.
- Gapped returns: valid pulses with 0-3 idle cycles between words -> exactly 8 data writes in order, then TAG exactly one cycle after the 8th valid.
- Spurious inputs:
  - miss_detected held high during FILL -> no relatch; base stays 0x1230.
  - A 9th valid after TAG -> no write_data_array.
  - Valid in IDLE -> no write.
- Reset mid-fill: assert rst=0 after the 3rd data word -> outputs 0 asynchronously, no write_tag_array. A fresh miss at 0x0040 then completes normally, with tag_out=0x00.

Source files
------------

// File: rtl/icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl
//   Instruction-cache miss handler. On a miss it issues one read per word of
//   the faulting block to the pipelined, in-order instruction memory, streams
//   each returned word into the data array, then writes the block tag into the
//   metadata array. The fetch stage is stalled for the whole fill.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   miss_detected       miss indication (sampled only while idle)
//   miss_address[15:0]  faulting fetch address
//   memory_data_valid   read data valid from instruction memory
//   memory_data[15:0]   read data from instruction memory
//   fsm_busy            stall request to the fetch stage
//   memory_enable       memory read request
//   memory_address      memory read address
//   write_data_array    data array write enable (one word)
//   fill_address        data array word address being written
//   fill_data           word written to the data array
//   write_tag_array     metadata array write enable
//   tag_out             tag written to the metadata array
// -----------------------------------------------------------------------------
module icache_fill_ctrl #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned TAG_W           = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [15:0]       miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              memory_enable,
  output logic [15:0]       memory_address,
  output logic              write_data_array,
  output logic [15:0]       fill_address,
  output logic [15:0]       fill_data,
  output logic              write_tag_array,
  output logic [TAG_W-1:0]  tag_out
);

  localparam int unsigned CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);
  // Clears the byte offset within a block (16-bit words, so 2 bytes/word).
  localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    TAG
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      base_q, base_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
  logic             issue_done_q, issue_done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      tag_q        <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      tag_q        <= tag_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      issue_done_q <= issue_done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    tag_d            = tag_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    issue_done_d     = issue_done_q;

    fsm_busy         = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_address     = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d       = miss_address & BLK_MASK;
          tag_d        = miss_address[15 -: TAG_W];
          issue_cnt_d  = '0;
          recv_cnt_d   = '0;
          issue_done_d = 1'b0;
          state_d      = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;

        // Issue side: no backpressure, so one read per cycle until the
        // counter wraps back to zero.
        if (!issue_done_q) begin
          memory_enable  = 1'b1;
          memory_address = base_q + 16'({issue_cnt_q, 1'b0});
          issue_cnt_d    = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_WORD) begin
            issue_done_d = 1'b1;
          end
        end

        // Receive side runs independently and may overlap issue; memory is
        // in-order, so the receive counter alone addresses the word.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_address     = base_q + 16'({recv_cnt_q, 1'b0});
          fill_data        = memory_data;
          recv_cnt_d       = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST_WORD) begin
            state_d = TAG;
          end
        end
      end

      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tag_out = tag_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_fill_ctrl
//   Randomized bench for icache_fill_ctrl. A behavioural in-order memory with
//   configurable latency and random gaps answers the DUT's reads. Each miss
//   pushes the expected read addresses, data-array writes and tag write into
//   queues; a negedge monitor pops and compares whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] fill_address;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [5:0]  tag_out;

  icache_fill_ctrl #(
    .WORDS_PER_BLOCK(8),
    .TAG_W          (6)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .fsm_busy         (fsm_busy),
    .memory_enable    (memory_enable),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .fill_address     (fill_address),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array),
    .tag_out          (tag_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] addr;
    int unsigned ready;
  } req_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_iss[$];
  logic [5:0]  exp_tag[$];
  req_t        pend[$];

  // memory model configuration
  logic [15:0] salt = '0;
  int unsigned lat = 4;
  bit          gapped = 1'b0;
  bit          extra9 = 1'b0;
  bit          drv_en = 1'b0;
  int unsigned inject = 0;
  int unsigned gap_left = 0;
  int unsigned popped = 0;

  // per-fill observations
  bit          in_fill = 1'b0;
  bit          tag_seen = 1'b0;
  int unsigned wr_fill = 0;
  int unsigned wr_total = 0;
  int unsigned busy_cnt = 0;
  int unsigned c0 = 0;
  int          first_iss = -1, last_iss = -1;
  int          first_wr = -1, last_wr = -1, tag_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: strobe with nothing expected, value 0x%0h (t=%0t)", name, act, $time);
  endtask

  // Memory contents: word i of any block reads as salt + i.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return salt + 16'(a[3:1]);
  endfunction

  // Monitor / scoreboard
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("fsm_busy", 64'(fsm_busy), 64'(in_fill));
        if (fsm_busy) busy_cnt++;
        if (memory_enable) begin
          if (exp_iss.size() == 0) unexpected("spurious_issue", 64'(memory_address));
          else check("memory_address", 64'(memory_address), 64'(exp_iss.pop_front()));
          pend.push_back('{memory_address, cyc + lat});
          if (first_iss < 0) first_iss = int'(cyc);
          last_iss = int'(cyc);
        end
        if (write_data_array) begin
          wr_total++;
          wr_fill++;
          if (exp_wr.size() == 0) unexpected("spurious_write", 64'(fill_address));
          else begin
            w = exp_wr.pop_front();
            check("fill_address", 64'(fill_address), 64'(w.addr));
            check("fill_data", 64'(fill_data), 64'(w.data));
          end
          if (first_wr < 0) first_wr = int'(cyc);
          last_wr = int'(cyc);
        end
        if (write_tag_array) begin
          if (exp_tag.size() == 0) unexpected("spurious_tag", 64'(tag_out));
          else check("tag_out", 64'(tag_out), 64'(exp_tag.pop_front()));
          check("words_before_tag", 64'(exp_wr.size()), 64'(0));
          check("tag_after_last_word", 64'(int'(cyc) - last_wr), 64'(1));
          tag_cyc  = int'(cyc);
          tag_seen = 1'b1;
          in_fill  = 1'b0;
        end
      end
    end
  end

  // In-order memory model answering the DUT's reads
  initial begin
    req_t r;
    forever begin
      @(posedge clk);
      #1;
      if (!drv_en) continue;
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
      if (inject > 0) begin
        memory_data_valid = 1'b1;
        inject--;
      end else if (gap_left > 0) begin
        gap_left--;
      end else if (pend.size() > 0 && pend[0].ready <= cyc) begin
        r = pend.pop_front();
        memory_data_valid = 1'b1;
        memory_data       = mem_word(r.addr);
        gap_left          = gapped ? $urandom_range(0, 3) : 0;
        popped++;
        if (popped == 8 && extra9) inject = 1;
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({fsm_busy, memory_enable, memory_address, write_data_array,
                fill_address, fill_data, write_tag_array, tag_out});
  endfunction

  task automatic do_fill(input logic [15:0] addr, input int unsigned lat_i,
                         input bit gapped_i, input bit extra_i, input bit hold,
                         input int unsigned abort_after, input logic [15:0] s);
    logic [15:0] base;
    int unsigned n;
    @(posedge clk);
    #1;
    salt = s; lat = lat_i; gapped = gapped_i; extra9 = extra_i;
    popped = 0; gap_left = 0; wr_fill = 0; busy_cnt = 0; tag_seen = 1'b0;
    first_iss = -1; last_iss = -1; first_wr = -1; last_wr = -1; tag_cyc = -1;
    base = {addr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) begin
      exp_iss.push_back(base + 16'(2 * i));
      exp_wr.push_back('{base + 16'(2 * i), s + 16'(i)});
    end
    exp_tag.push_back(addr[15:10]);
    miss_address  = addr;
    miss_detected = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    in_fill = 1'b1;
    if (!hold) miss_detected = 1'b0;
    n = 0;
    while (!tag_seen && n < 400) begin
      @(negedge clk);
      #1;
      n++;
      if (tag_seen) break;
      if (hold) miss_address = 16'($urandom);
      if (abort_after > 0 && wr_fill >= abort_after) begin
        exp_wr.delete(); exp_iss.delete(); exp_tag.delete();
        drv_en = 1'b0;
        pend.delete();
        inject = 0;
        miss_detected = 1'b0;
        memory_data_valid = 1'b1;
        rst = 1'b0;
        #1;
        check("abort_outputs_zero", all_outs(), 64'(0));
        in_fill = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        memory_data_valid = 1'b0;
        rst = 1'b1;
        drv_en = 1'b1;
        return;
      end
    end
    miss_detected = 1'b0;
    if (!tag_seen) unexpected("fill_timeout", 64'(wr_fill));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0;
    rst = 1'b0;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data_valid = 1'b0;
    memory_data = '0;

    // reset with random inputs
    for (int i = 0; i < 6; i++) begin
      #3;
      miss_detected     = 1'($urandom);
      miss_address      = 16'($urandom);
      memory_data_valid = 1'($urandom);
      memory_data       = 16'($urandom);
      #1;
      check("reset_outputs", all_outs(), 64'(0));
    end
    @(posedge clk);
    #2;
    miss_detected = 1'b0;
    memory_data_valid = 1'b0;
    rst = 1'b1;
    drv_en = 1'b1;
    busy_cnt = 0;
    repeat (20) @(negedge clk);
    check("idle_busy_cycles", 64'(busy_cnt), 64'(0));

    // basic fill with 4-cycle memory
    do_fill(16'h1236, 4, 1'b0, 1'b0, 1'b0, 0, 16'hA000);
    check("first_issue_cycle", 64'(first_iss - int'(c0)), 64'(1));
    check("last_issue_cycle", 64'(last_iss - int'(c0)), 64'(8));
    check("first_write_cycle", 64'(first_wr - int'(c0)), 64'(5));
    check("last_write_cycle", 64'(last_wr - int'(c0)), 64'(12));
    check("tag_cycle", 64'(tag_cyc - int'(c0)), 64'(13));
    check("busy_cycles", 64'(busy_cnt), 64'(13));

    // top of memory
    do_fill(16'hFFFA, 4, 1'b0, 1'b0, 1'b0, 0, 16'($urandom));
    check("top_write_count", 64'(wr_fill), 64'(8));

    // gapped returns
    for (int i = 0; i < 3; i++) begin
      do_fill(16'($urandom), $urandom_range(1, 6), 1'b1, 1'b0, 1'b0, 0, 16'($urandom));
      check("gapped_write_count", 64'(wr_fill), 64'(8));
    end

    // miss held high during fill
    do_fill(16'h1236, 3, 1'b0, 1'b0, 1'b1, 0, 16'($urandom));
    repeat (3) @(negedge clk);
    check("held_miss_no_refill", 64'(fsm_busy), 64'(0));

    // ninth valid in TAG cycle
    do_fill(16'($urandom), 2, 1'b0, 1'b1, 1'b0, 0, 16'($urandom));
    repeat (3) @(negedge clk);
    check("ninth_valid_writes", 64'(wr_fill), 64'(8));

    // valid while idle
    w0 = wr_total;
    inject = 3;
    repeat (6) @(negedge clk);
    check("idle_valid_writes", 64'(wr_total), 64'(w0));

    // reset after the third data word, then a fresh miss
    do_fill(16'($urandom), 4, 1'b0, 1'b0, 1'b0, 3, 16'($urandom));
    repeat (5) @(negedge clk);
    check("abort_no_tag", 64'(tag_seen), 64'(0));
    do_fill(16'h0040, 4, 1'b0, 1'b0, 1'b0, 0, 16'($urandom));
    check("after_abort_write_count", 64'(wr_fill), 64'(8));

    // random fills
    for (int i = 0; i < 8; i++) begin
      do_fill(16'($urandom), $urandom_range(1, 8), 1'($urandom), 1'($urandom),
              1'($urandom), 0, 16'($urandom));
    end

    repeat (5) @(negedge clk);
    check("queues_drained", 64'(exp_wr.size() + exp_iss.size() + exp_tag.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
